// File: rtl/inst_rom_loader_if.sv
// Fetch + boot-loader bundle between the CPU core / loader (master) and
// the instruction ROM (slave). DEPTH_LOG2 sizes the words_loaded count and
// must match the DEPTH_LOG2 of the attached inst_rom_loader.
interface inst_rom_loader_if #(
   parameter int unsigned DEPTH_LOG2 = 10
);
   // fetch side
   logic                  ce;
   logic [31:0]           addr;
   logic [31:0]           inst;
   // loader side
   logic                  load_valid;
   logic [7:0]            load_byte;
   logic                  load_last;
   logic                  load_ready;
   logic                  reload;
   // status
   logic                  boot_done;
   logic [DEPTH_LOG2:0]   words_loaded;
   logic [31:0]           checksum;

   modport master (
      output ce, addr, load_valid, load_byte, load_last, reload,
      input  inst, load_ready, boot_done, words_loaded, checksum
   );

   modport slave (
      input  ce, addr, load_valid, load_byte, load_last, reload,
      output inst, load_ready, boot_done, words_loaded, checksum
   );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM with boot loader. After reset (or reload) it assembles a
// big-endian byte stream into 32-bit words and writes them from word 0 up;
// once the image ends (load_last or memory full) it serves combinational
// fetches. Anything not fetchable returns NOP_WORD.
// Optional build macro: INST_ROM_CHECKSUM_EN enables the running checksum
// of written words; without it the checksum output is tied to zero.
module inst_rom_loader #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   inst_rom_loader_if.slave   bus
);

   localparam int unsigned         DEPTH     = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LAST_WORD = (DEPTH_LOG2 + 1)'(DEPTH - 1);

   typedef enum logic {
      S_LOAD = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   // Only the three most recent bytes are needed to finish a word, so the
   // top byte of the assembly register is never stored.
   logic [23:0]           asm_q, asm_d;
   logic [DEPTH_LOG2:0]   words_q, words_d;

   logic [31:0]           mem_q [DEPTH];

   logic                  accept;
   logic                  word_end;
   logic                  wr_en;
   logic [31:0]           wr_data;
   logic [DEPTH_LOG2-1:0] wr_addr;

   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  rd_hi_zero;
   logic                  rd_hit;
   logic                  addr_lsb_unused;

   assign accept   = bus.load_valid && (state_q == S_LOAD);
   assign word_end = accept && ((byte_cnt_q == 2'd3) || bus.load_last);
   assign wr_addr  = words_q[DEPTH_LOG2-1:0];

   // Word to write: full word on the 4th byte, left-justified and
   // zero-padded when load_last arrives early.
   always_comb begin
      wr_data = '0;
      case (byte_cnt_q)
         2'd0:    wr_data = {bus.load_byte, 24'h00_0000};
         2'd1:    wr_data = {asm_q[7:0], bus.load_byte, 16'h0000};
         2'd2:    wr_data = {asm_q[15:0], bus.load_byte, 8'h00};
         default: wr_data = {asm_q, bus.load_byte};
      endcase
   end

   // Next-state: reload dominates any byte; a completed word advances the
   // write pointer and ends loading on load_last or when memory fills.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      words_d    = words_q;
      wr_en      = 1'b0;
      if (bus.reload) begin
         state_d    = S_LOAD;
         byte_cnt_d = '0;
         asm_d      = '0;
         words_d    = '0;
      end else if (accept) begin
         asm_d      = {asm_q[15:0], bus.load_byte};
         byte_cnt_d = byte_cnt_q + 2'd1;
         if (word_end) begin
            wr_en      = 1'b1;
            byte_cnt_d = '0;
            asm_d      = '0;
            words_d    = words_q + 1'b1;
            if (bus.load_last || (words_q == LAST_WORD)) begin
               state_d = S_RUN;
            end
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LOAD;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= state_d == state_q ? byte_cnt_d : byte_cnt_d;
         asm_q      <= asm_d;
         words_q    <= words_d;
      end
   end

   // Word array: not reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

`ifdef INST_ROM_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;

   // Checksum next value: sum of written words, cleared when loading restarts.
   always_comb begin
      csum_d = csum_q;
      if (bus.reload) begin
         csum_d = '0;
      end else if (wr_en) begin
         csum_d = csum_q + wr_data;
      end
   end

   // Checksum register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign bus.checksum = csum_q;
`else
   assign bus.checksum = '0;
`endif

   // Fetch decode: byte address to word index; high bits must be zero and
   // the word must have been written since the last load start.
   assign rd_idx          = bus.addr[DEPTH_LOG2+1:2];
   assign rd_hi_zero      = (bus.addr[31:DEPTH_LOG2+2] == '0);
   assign rd_hit          = bus.ce && (state_q == S_RUN) && rd_hi_zero &&
                            ({1'b0, rd_idx} < words_q);
   assign addr_lsb_unused = ^bus.addr[1:0];

   assign bus.inst         = rd_hit ? mem_q[rd_idx] : NOP_WORD;
   assign bus.load_ready   = (state_q == S_LOAD);
   assign bus.boot_done    = (state_q == S_RUN);
   assign bus.words_loaded = words_q;

endmodule
